// File: rtl/ex_muldiv_ctrl.sv
// ex_muldiv_ctrl: iterative shift-add multiply / restoring divide sequencer with EX stall request.
// Optional MULDIV_SIGNED_EN adds signed_i for two's-complement operands.
module ex_muldiv_ctrl #(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic              op_i,
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
`ifdef MULDIV_SIGNED_EN
    input  logic              signed_i,
`endif
    input  logic              flush_i,
    output logic              stall_o,
    output logic              done_o,
    output logic [DATA_W-1:0] lo_o,
    output logic [DATA_W-1:0] hi_o,
    output logic              div_zero_o
);
    localparam int CW = $clog2(DATA_W);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]          state;
    logic [CW-1:0]       cnt;
    logic                is_div, dz, neg_q, neg_r;
    logic [DATA_W-1:0]   opnd, work_hi, work_lo;
    logic                sa, sb, accept, last, fits;
    logic [DATA_W-1:0]   mag_a, mag_b, nxt_hi, nxt_lo, fin_hi, fin_lo;
    logic [DATA_W:0]     sum, shl;
    logic [2*DATA_W-1:0] prod;

`ifdef MULDIV_SIGNED_EN
    assign sa = signed_i && a_i[DATA_W-1];
    assign sb = signed_i && b_i[DATA_W-1];
`else
    assign sa = 1'b0;
    assign sb = 1'b0;
`endif

    assign mag_a      = sa ? -a_i : a_i;
    assign mag_b      = sb ? -b_i : b_i;
    assign accept     = state == IDLE && start_i && !flush_i;
    assign last       = cnt == CW'(DATA_W - 1);
    assign stall_o    = accept || state == RUN;
    assign done_o     = state == DONE;
    assign div_zero_o = done_o && dz;

    // work_hi/work_lo hold accumulator/multiplier for multiply and remainder/dividend-quotient for divide
    always_comb begin
        sum    = {1'b0, work_hi} + (work_lo[0] ? {1'b0, opnd} : '0);
        shl    = {work_hi, work_lo[DATA_W-1]};
        fits   = shl >= {1'b0, opnd};
        nxt_hi = is_div ? (fits ? shl[DATA_W-1:0] - opnd : shl[DATA_W-1:0]) : sum[DATA_W:1];
        nxt_lo = is_div ? {work_lo[DATA_W-2:0], fits} : {sum[0], work_lo[DATA_W-1:1]};
        prod   = neg_q ? -{nxt_hi, nxt_lo} : {nxt_hi, nxt_lo};
        fin_lo = is_div ? (neg_q ? -nxt_lo : nxt_lo) : prod[DATA_W-1:0];
        fin_hi = is_div ? (neg_r ? -nxt_hi : nxt_hi) : prod[2*DATA_W-1:DATA_W];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            is_div  <= 1'b0;
            dz      <= 1'b0;
            neg_q   <= 1'b0;
            neg_r   <= 1'b0;
            opnd    <= '0;
            work_hi <= '0;
            work_lo <= '0;
            lo_o    <= '0;
            hi_o    <= '0;
        end else if (flush_i) begin
            state <= IDLE;
        end else if (accept) begin
            is_div  <= op_i;
            dz      <= op_i && b_i == '0;
            neg_q   <= sa ^ sb;
            neg_r   <= sa;
            opnd    <= op_i ? mag_b : mag_a;
            work_hi <= '0;
            work_lo <= op_i ? mag_a : mag_b;
            cnt     <= '0;
            if (op_i && b_i == '0) begin
                lo_o  <= '1;
                hi_o  <= a_i;
                state <= DONE;
            end else begin
                state <= RUN;
            end
        end else if (state == RUN) begin
            work_hi <= nxt_hi;
            work_lo <= nxt_lo;
            cnt     <= cnt + 1'b1;
            if (last) begin
                lo_o  <= fin_lo;
                hi_o  <= fin_hi;
                state <= DONE;
            end
        end else if (state != IDLE) begin
            state <= IDLE;
        end
    end
endmodule

// File: tb/tb_ex_muldiv_ctrl.sv
// tb_ex_muldiv_ctrl: randomized and directed check of ex_muldiv_ctrl against an arithmetic reference model.
module tb_ex_muldiv_ctrl;
    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst, start, op, flush, sgn;
    logic [W-1:0] a, b;
    logic         stall, done, dz_out;
    logic [W-1:0] lo, hi;

    int total = 0;
    int bad = 0;
    int n, done_at, acc_n, lat;
    bit busy, last_done, r_dz, got;
    logic [W-1:0] m_lo, m_hi, r_lo, r_hi;

    always #5 clk = ~clk;

    ex_muldiv_ctrl #(.DATA_W(W)) dut (
        .clk(clk),
        .rst(rst),
        .start_i(start),
        .op_i(op),
        .a_i(a),
        .b_i(b),
`ifdef MULDIV_SIGNED_EN
        .signed_i(sgn),
`endif
        .flush_i(flush),
        .stall_o(stall),
        .done_o(done),
        .lo_o(lo),
        .hi_o(hi),
        .div_zero_o(dz_out)
    );

    // returns {div_zero, hi, lo} computed with plain integer arithmetic
    function automatic logic [2*W:0] model(input logic o, input logic s, input logic [W-1:0] x, input logic [W-1:0] y);
        longint xa, yb, p, q, r;
        if (s) begin
            xa = longint'($signed(x));
            yb = longint'($signed(y));
        end else begin
            xa = longint'(x);
            yb = longint'(y);
        end
        if (!o) begin
            p = xa * yb;
            return {1'b0, p[2*W-1:0]};
        end
        if (y == '0) return {1'b1, x, {W{1'b1}}};
        q = xa / yb;
        r = xa % yb;
        return {1'b0, r[W-1:0], q[W-1:0]};
    endfunction

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, n);
        end
    endtask

    task automatic step();
        bit exp_done, exp_stall;
        @(negedge clk);
        exp_done  = busy && n == done_at;
        exp_stall = (busy && n < done_at) || (!busy && start && !flush);
        if (exp_done) begin
            m_lo = r_lo;
            m_hi = r_hi;
            lat  = n - acc_n;
        end
        last_done = exp_done;
        check("stall", stall, exp_stall);
        check("done", done, exp_done);
        check("div_zero", dz_out, exp_done && r_dz);
        check("lo", lo, m_lo);
        check("hi", hi, m_hi);
        if (rst) begin
            busy = 0;
            m_lo = '0;
            m_hi = '0;
        end else if (flush) begin
            busy = 0;
        end else if (busy && n == done_at) begin
            busy = 0;
        end else if (!busy && start) begin
            {r_dz, r_hi, r_lo} = model(op, sgn, a, b);
            acc_n   = n;
            done_at = n + (r_dz ? 1 : W + 1);
            busy    = 1;
        end
        n++;
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input logic o, input logic s, input logic [W-1:0] x, input logic [W-1:0] y);
        op = o; sgn = s; a = x; b = y;
        start = 1; flush = 0; rst = 0;
        got = 0;
        for (int i = 0; i < 40 && !got; i++) begin
            step();
            got = last_done;
        end
        start = 0;
        check("op_complete", got, 1);
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 5))
            0: return '0;
            1: return '1;
            2: return {1'b1, {(W-1){1'b0}}};
            3: return W'(1);
            default: return W'($urandom);
        endcase
    endfunction

    initial begin
        rst = 1; start = 0; op = 0; flush = 0; sgn = 0; a = '0; b = '0;
        busy = 0; m_lo = '0; m_hi = '0; r_lo = '0; r_hi = '0; r_dz = 0;
        n = 0; done_at = 0; acc_n = 0; lat = 0;
        repeat (2) @(posedge clk);
        #1;
        step();
        rst = 0;
        step();

        check("model_mul", model(0, 0, 16'h1234, 16'h0010), {1'b0, 16'h0001, 16'h2340});
        check("model_div", model(1, 0, 16'd100, 16'd7), {1'b0, 16'h0002, 16'h000E});
        check("model_dz", model(1, 0, 16'h0055, 16'h0000), {1'b1, 16'h0055, 16'hFFFF});
        check("model_umax", model(0, 0, 16'hFFFF, 16'hFFFF), {1'b0, 16'hFFFE, 16'h0001});
        check("model_smul", model(0, 1, 16'hFFFF, 16'hFFFF), {1'b0, 16'h0000, 16'h0001});
        check("model_sdiv", model(1, 1, 16'hFFF9, 16'h0002), {1'b0, 16'hFFFF, 16'hFFFD});

        run_op(1, 0, 16'h0055, 16'h0000);
        check("dz_latency", lat, 1);
        check("dz_lo_lit", lo, 16'hFFFF);
        check("dz_hi_lit", hi, 16'h0055);
        step();
        run_op(1, 0, 16'd100, 16'd7);
        check("div_lo_lit", lo, 16'h000E);
        check("div_hi_lit", hi, 16'h0002);
        run_op(0, 0, 16'hFFFF, 16'hFFFF);
        check("umax_hi_lit", hi, 16'hFFFE);
        run_op(0, 0, 16'h1234, 16'h0010);
        check("mul_latency", lat, 17);
        check("mul_lo_lit", lo, 16'h2340);
        check("mul_hi_lit", hi, 16'h0001);

        op = 1; a = 16'd100; b = 16'd7; start = 1;
        repeat (6) step();
        flush = 1;
        step();
        flush = 0; start = 0;
        check("flush_stall_lit", stall, 0);
        step();
        check("flush_lo_lit", lo, 16'h2340);
        check("flush_hi_lit", hi, 16'h0001);

        op = 0; a = 16'h00FF; b = 16'h0101; start = 1;
        repeat (9) step();
        rst = 1;
        step();
        rst = 0;
        check("rst_lo_lit", lo, 16'h0000);
        check("rst_hi_lit", hi, 16'h0000);
        check("rst_done_lit", done, 0);
        run_op(1, 0, 16'd100, 16'd7);
        check("after_rst_lat", lat, 17);

`ifdef MULDIV_SIGNED_EN
        run_op(0, 1, 16'hFFFF, 16'hFFFF);
        check("smul_lo_lit", lo, 16'h0001);
        check("smul_hi_lit", hi, 16'h0000);
        run_op(1, 1, 16'hFFF9, 16'h0002);
        check("sdiv_lo_lit", lo, 16'hFFFD);
        check("sdiv_hi_lit", hi, 16'hFFFF);
        run_op(1, 1, 16'h8000, 16'h0000);
        check("sdz_hi_lit", hi, 16'h8000);
`endif

        for (int c = 0; c < 6000; c++) begin
            if (!busy) begin
                start = $urandom_range(0, 2) != 0;
                op    = 1'($urandom_range(0, 1));
                a     = pick();
                b     = (op && $urandom_range(0, 4) == 0) ? '0 : pick();
`ifdef MULDIV_SIGNED_EN
                sgn   = 1'($urandom_range(0, 1));
`endif
            end else begin
                start = 1;
                a     = W'($urandom);
                b     = W'($urandom);
            end
            flush = $urandom_range(0, 39) == 0;
            rst   = $urandom_range(0, 149) == 0;
            step();
        end

        rst = 0; flush = 0; start = 0;
        step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
